// File: rtl/halut_int_decoder.sv
// HALUT integer decoder: accumulates LUT entries selected by a stream of
// per-codebook prototype indices into one result vector per input row.
module halut_int_decoder #(
  parameter int K             = 16,
  parameter int C             = 32,
  parameter int MCols         = 2,
  parameter int DataTypeWidth = 16,
  parameter int AccWidth      = 32,
  parameter int Saturate      = 1,
  localparam int KW = $clog2(K),
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int MW = (MCols > 1) ? $clog2(MCols) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      lut_we_i,
  input  logic [MW-1:0]             lut_col_i,
  input  logic [CW-1:0]             lut_c_i,
  input  logic [KW-1:0]             lut_k_i,
  input  logic [DataTypeWidth-1:0]  lut_data_i,
  input  logic                      enc_valid_i,
  output logic                      enc_ready_o,
  input  logic [KW-1:0]             enc_idx_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [MCols*AccWidth-1:0] out_data_o,
  output logic [31:0]               row_cnt_o
);

  localparam logic [CW-1:0] CLast = CW'(C - 1);

  logic [DataTypeWidth-1:0]         lut_q [MCols][C][K];
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [MCols-1:0][AccWidth-1:0]   acc_q, acc_d, out_q, out_d, res;
  logic                             out_valid_q, out_valid_d;
  logic [31:0]                      row_cnt_q, row_cnt_d;
  logic                             last, hs;

  // LUT contents survive reset; reads are combinational so a same-cycle
  // write is only visible from the next cycle on.
  always_ff @(posedge clk_i) begin
    if (lut_we_i) lut_q[lut_col_i][lut_c_i][lut_k_i] <= lut_data_i;
  end

  assign last        = (cnt_q == CLast);
  assign enc_ready_o = !(last && out_valid_q && !out_ready_i);
  assign hs          = enc_valid_i && enc_ready_o;

  for (genvar j = 0; j < MCols; j++) begin : g_col
    logic [DataTypeWidth-1:0] entry;
    logic [AccWidth-1:0]      base;
    logic [AccWidth:0]        sum;
    assign entry = lut_q[j][cnt_q][enc_idx_i];
    // cnt == 0 starts a fresh row, so the old accumulator is ignored
    assign base  = (cnt_q == '0) ? '0 : acc_q[j];
    assign sum   = {base[AccWidth-1], base}
                 + {{(AccWidth + 1 - DataTypeWidth){entry[DataTypeWidth-1]}}, entry};
    if (Saturate != 0) begin : g_sat
      // one extra bit disagreeing with the sign bit means overflow
      assign res[j] = (sum[AccWidth] != sum[AccWidth-1])
                    ? (sum[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                     : {1'b0, {(AccWidth-1){1'b1}}})
                    : sum[AccWidth-1:0];
    end else begin : g_wrap
      assign res[j] = sum[AccWidth-1:0];
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    row_cnt_d   = row_cnt_q;
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      row_cnt_d   = row_cnt_q + 32'd1;
    end
    if (hs) begin
      if (last) begin
        out_d       = res;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        acc_d = res;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      row_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign row_cnt_o   = row_cnt_q;

endmodule

// File: tb/tb_halut_int_decoder.sv
// Scoreboard bench for halut_int_decoder: a main instance (K=16,C=4,MCols=2)
// plus saturating and wrapping 16-bit accumulator instances sharing one stream.
module tb_halut_int_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic        m_we, m_valid, m_ready, m_ovalid, m_oready;
  logic [0:0]  m_col;
  logic [1:0]  m_c;
  logic [3:0]  m_k, m_idx;
  logic [15:0] m_data;
  logic [63:0] m_odata;
  logic [31:0] m_rows;

  logic        a_we, a_valid, a_oready;
  logic [0:0]  a_col, a_k, a_idx;
  logic [1:0]  a_c;
  logic [15:0] a_data;
  logic        s_ready, s_ovalid, w_ready, w_ovalid;
  logic [31:0] s_odata, w_odata, s_rows, w_rows;

  halut_int_decoder #(.K(16), .C(4), .MCols(2), .DataTypeWidth(16), .AccWidth(32), .Saturate(1)) u_main (
    .clk_i(clk), .rst_i(rst), .lut_we_i(m_we), .lut_col_i(m_col), .lut_c_i(m_c), .lut_k_i(m_k),
    .lut_data_i(m_data), .enc_valid_i(m_valid), .enc_ready_o(m_ready), .enc_idx_i(m_idx),
    .out_valid_o(m_ovalid), .out_ready_i(m_oready), .out_data_o(m_odata), .row_cnt_o(m_rows));

  halut_int_decoder #(.K(2), .C(4), .MCols(2), .DataTypeWidth(16), .AccWidth(16), .Saturate(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .lut_we_i(a_we), .lut_col_i(a_col), .lut_c_i(a_c), .lut_k_i(a_k),
    .lut_data_i(a_data), .enc_valid_i(a_valid), .enc_ready_o(s_ready), .enc_idx_i(a_idx),
    .out_valid_o(s_ovalid), .out_ready_i(a_oready), .out_data_o(s_odata), .row_cnt_o(s_rows));

  halut_int_decoder #(.K(2), .C(4), .MCols(2), .DataTypeWidth(16), .AccWidth(16), .Saturate(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .lut_we_i(a_we), .lut_col_i(a_col), .lut_c_i(a_c), .lut_k_i(a_k),
    .lut_data_i(a_data), .enc_valid_i(a_valid), .enc_ready_o(w_ready), .enc_idx_i(a_idx),
    .out_valid_o(w_ovalid), .out_ready_i(a_oready), .out_data_o(w_odata), .row_cnt_o(w_rows));

  logic [63:0] mq[$];
  logic [31:0] sq[$], wq[$];
  int          mlut [2][4][16];
  logic        b2b = 1'b0;
  int          stall_cnt = 0;

  // Monitors: every consumed result is popped and compared.
  always @(negedge clk) begin
    if (!rst && m_ovalid && m_oready) begin
      checks++;
      if (mq.size() == 0) begin
        errors++; $display("FAIL main_unexpected got %h", m_odata);
      end else begin
        logic [63:0] e;
        e = mq.pop_front();
        if (m_odata !== e) begin errors++; $display("FAIL main_result got %h exp %h", m_odata, e); end
      end
    end
    if (b2b && !m_ready) stall_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && s_ovalid && a_oready) begin
      checks++;
      if (sq.size() == 0) begin
        errors++; $display("FAIL sat_unexpected got %h", s_odata);
      end else begin
        logic [31:0] e;
        e = sq.pop_front();
        if (s_odata !== e) begin errors++; $display("FAIL sat_result got %h exp %h", s_odata, e); end
      end
    end
    if (!rst && w_ovalid && a_oready) begin
      checks++;
      if (wq.size() == 0) begin
        errors++; $display("FAIL wrap_unexpected got %h", w_odata);
      end else begin
        logic [31:0] e;
        e = wq.pop_front();
        if (w_odata !== e) begin errors++; $display("FAIL wrap_result got %h exp %h", w_odata, e); end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s got %h exp %h", name, got, exp); end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] exp_row(input int i0, input int i1, input int i2, input int i3);
    int s0, s1;
    s0 = mlut[0][0][i0] + mlut[0][1][i1] + mlut[0][2][i2] + mlut[0][3][i3];
    s1 = mlut[1][0][i0] + mlut[1][1][i1] + mlut[1][2][i2] + mlut[1][3][i3];
    return {s1[31:0], s0[31:0]};
  endfunction

  task automatic mwr(input int j, input int c, input int k, input int v);
    m_we = 1'b1; m_col = j[0:0]; m_c = c[1:0]; m_k = k[3:0]; m_data = v[15:0];
    cyc();
    m_we = 1'b0;
    mlut[j][c][k] = v;
  endtask

  // Holds valid until accepted; returns just after the handshake edge.
  task automatic msend(input int idx);
    int n;
    n = 0;
    m_valid = 1'b1; m_idx = idx[3:0]; #1;
    while (!m_ready && n < 100) begin cyc(); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL msend_timeout got ready=0 exp 1"); end
    cyc();
  endtask

  task automatic mrow(input int i0, input int i1, input int i2, input int i3);
    mq.push_back(exp_row(i0, i1, i2, i3));
    msend(i0); msend(i1); msend(i2); msend(i3);
  endtask

  task automatic asend(input int idx);
    a_valid = 1'b1; a_idx = idx[0:0]; #1;
    if (!s_ready) begin checks++; errors++; $display("FAIL asend_ready got 0 exp 1"); end
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    rst = 1'b1;
    m_we = 0; m_col = 0; m_c = 0; m_k = 0; m_data = 0; m_valid = 0; m_idx = 0; m_oready = 1;
    a_we = 0; a_col = 0; a_c = 0; a_k = 0; a_data = 0; a_valid = 0; a_idx = 0; a_oready = 1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", 64'(m_ovalid), 64'd0);
    chk("rst_out_data", m_odata, 64'd0);
    chk("rst_row_cnt", 64'(m_rows), 64'd0);
    chk("rst_enc_ready", 64'(m_ready), 64'd1);

    for (int j = 0; j < 2; j++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 16; k++) mwr(j, c, k, 10 * c + k + j);

    // First row: col0 = 1+12+23+34 = 70, col1 = 74; valid the edge after the 4th index
    mrow(1, 2, 3, 4);
    m_valid = 1'b0;
    chk("row1_valid", 64'(m_ovalid), 64'd1);
    chk("row1_hand", m_odata, {32'd74, 32'd70});
    cyc();
    chk("row1_row_cnt", 64'(m_rows), 64'd1);

    // Back-to-back rows, valid held high
    b2b = 1'b1; stall_cnt = 0;
    t0 = $time;
    mrow(0, 15, 7, 9);
    mrow(3, 3, 3, 3);
    mrow(15, 0, 1, 2);
    chk("b2b_cycles", 64'(($time - t0) / 10), 64'd12);
    m_valid = 1'b0;
    b2b = 1'b0;
    chk("b2b_no_stall", 64'(stall_cnt), 64'd0);
    cyc();
    chk("b2b_row_cnt", 64'(m_rows), 64'd4);

    // Backpressure: row A pending, row B stalls on its last index
    m_oready = 1'b0;
    mrow(5, 6, 7, 8);
    mq.push_back(exp_row(9, 10, 11, 12));
    msend(9); msend(10); msend(11);
    m_valid = 1'b1; m_idx = 4'd12;
    cyc(); cyc();
    chk("bp_ready_low", 64'(m_ready), 64'd0);
    chk("bp_valid_held", 64'(m_ovalid), 64'd1);
    chk("bp_data_held", m_odata, exp_row(5, 6, 7, 8));
    m_oready = 1'b1; #1;
    chk("bp_ready_comb", 64'(m_ready), 64'd1);
    cyc();
    m_valid = 1'b0;
    chk("bp_passthru_valid", 64'(m_ovalid), 64'd1);
    chk("bp_passthru_data", m_odata, exp_row(9, 10, 11, 12));
    cyc();
    chk("bp_row_cnt", 64'(m_rows), 64'd6);

    // Same-cycle LUT write to the entry being read: old value now, new next row
    mq.push_back(exp_row(2, 5, 0, 1));
    msend(2);
    m_we = 1'b1; m_col = 1'b0; m_c = 2'd1; m_k = 4'd5; m_data = 16'd1000;
    msend(5);
    m_we = 1'b0;
    mlut[0][1][5] = 1000;
    msend(0); msend(1);
    mrow(2, 5, 0, 1);
    m_valid = 1'b0;
    cyc();
    chk("wr_row_cnt", 64'(m_rows), 64'd8);

    // Reset mid-row with an unconsumed result pending: all discarded
    m_oready = 1'b0;
    msend(4); msend(4); msend(4); msend(4);
    msend(7); msend(7);
    m_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(m_ovalid), 64'd0);
    chk("mid_rst_data", m_odata, 64'd0);
    chk("mid_rst_row_cnt", 64'(m_rows), 64'd0);
    chk("mid_rst_ready", 64'(m_ready), 64'd1);
    m_oready = 1'b1;
    mrow(8, 1, 14, 6);
    m_valid = 1'b0;
    cyc();
    chk("post_rst_row_cnt", 64'(m_rows), 64'd1);

    // Saturating vs wrapping 16-bit accumulators: col0 all 0x7FFF, col1 all 0x8000
    for (int j = 0; j < 2; j++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 2; k++) begin
          a_we = 1'b1; a_col = j[0:0]; a_c = c[1:0]; a_k = k[0:0];
          a_data = (j == 1) ? 16'h8000 : 16'h7FFF;
          cyc();
        end
    a_we = 1'b0;
    sq.push_back({16'h8000, 16'h7FFF});
    wq.push_back({16'h0000, 16'hFFFC});
    asend(0); asend(1); asend(0); asend(1);
    a_valid = 1'b0;
    chk("sat_valid", 64'(s_ovalid), 64'd1);
    chk("wrap_valid", 64'(w_ovalid), 64'd1);
    cyc(); cyc();
    chk("sat_row_cnt", 64'(s_rows), 64'd1);

    chk("main_queue_empty", 64'(mq.size()), 64'd0);
    chk("sat_queue_empty", 64'(sq.size()), 64'd0);
    chk("wrap_queue_empty", 64'(wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
